// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: queue entry layout,
// fetch sequencer states and the PC step.
package fetch_queue_pkg;

   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t instr;
   } fetch_entry_t;

   typedef enum logic {FETCH, DISCARD} fetch_state_t;

   localparam word_t FETCH_INCREMENT = 32'd4;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries with clear; head is the oldest entry.
// Caller must not push when full or pop when empty.
module fetch_queue_fifo
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     push,
   input  logic                     pop,
   input  fetch_entry_t             wdata,
   output fetch_entry_t             head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);

   fetch_entry_t    mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [AW:0]     count_q;

   // Storage is not reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push && !clear && !reset) mem_q[wr_ptr_q] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetch sequencer, PC register and head mux.
// Optional same-cycle bypass of an empty queue: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH         = 4,
   parameter logic [31:0] RESET_ADDRESS = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   output logic        mem_valid,
   output logic [31:0] mem_address,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_pc,
   input  logic        out_ready
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t  state_q, state_d;
   word_t         fetch_pc_q, fetch_pc_d;
   word_t         hold_addr_q, hold_addr_d;
   word_t         flush_target;
   logic [CW-1:0] count;
   fetch_entry_t  head, wentry;
   logic          push, pop, bypass_take;

   assign flush_target = flush_pc & ~32'h3;
   assign wentry       = '{pc: fetch_pc_q, instr: mem_rdata};

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      hold_addr_d = hold_addr_q;
      mem_valid   = 1'b0;
      mem_address = fetch_pc_q;
      out_valid   = (count != '0);
      out_instr   = head.instr;
      out_pc      = head.pc;
      push        = 1'b0;
      bypass_take = 1'b0;
      case (state_q)
         FETCH: begin
            mem_valid = (count < CW'(DEPTH));
`ifdef FETCH_QUEUE_BYPASS_EN
            if (count == '0 && mem_ready && !flush) begin
               out_valid   = 1'b1;
               out_instr   = mem_rdata;
               out_pc      = fetch_pc_q;
               bypass_take = out_ready;
            end
`endif
            if (flush) begin
               fetch_pc_d = flush_target;
               // An issued request cannot be withdrawn; swallow its response.
               if (mem_valid && !mem_ready) begin
                  state_d     = DISCARD;
                  hold_addr_d = fetch_pc_q;
               end
            end else if (mem_valid && mem_ready) begin
               push       = !bypass_take;
               fetch_pc_d = fetch_pc_q + FETCH_INCREMENT;
            end
         end
         DISCARD: begin
            mem_valid   = 1'b1;
            mem_address = hold_addr_q;
            if (flush)     fetch_pc_d = flush_target;
            if (mem_ready) state_d    = FETCH;
         end
         default: state_d = FETCH;
      endcase
      pop = (count != '0) && out_ready && !flush;
      if (reset) begin
         mem_valid = 1'b0;
         out_valid = 1'b0;
         push      = 1'b0;
         pop       = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FETCH;
         fetch_pc_q  <= RESET_ADDRESS;
         hold_addr_q <= RESET_ADDRESS;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         hold_addr_q <= hold_addr_d;
      end
   end

   fetch_queue_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .clear (flush),
      .push  (push),
      .pop   (pop),
      .wdata (wentry),
      .head  (head),
      .count (count)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference model predicts bus requests
// and the delivered {pc, instr} stream; directed phases plus random backpressure.
module tb_fetch_queue;

   localparam logic [31:0] RST_ADDR = 32'h100;

   logic        clk = 1'b0;
   logic        reset, flush, mem_ready, out_ready;
   logic [31:0] flush_pc;
   logic        mem_valid, out_valid;
   logic [31:0] mem_address, mem_rdata, out_instr, out_pc;

   int          nchecks = 0;
   int          nerr    = 0;
   int          npop    = 0;
   int          ws      = 0;

   logic [63:0] sb[$];
   logic [31:0] exp_pc, hold;
   logic        disc;

   always #5 clk = ~clk;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A5A, ~a[31:16]};
   endfunction

   assign mem_rdata = memf(mem_address);

   fetch_queue #(.DEPTH(4), .RESET_ADDRESS(RST_ADDR)) dut (
      .clk         (clk),
      .reset       (reset),
      .flush       (flush),
      .flush_pc    (flush_pc),
      .mem_valid   (mem_valid),
      .mem_address (mem_address),
      .mem_ready   (mem_ready),
      .mem_rdata   (mem_rdata),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .out_ready   (out_ready)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Reference model, evaluated mid-cycle when inputs for the next edge are stable.
   always @(negedge clk) begin
      logic        emv, eov;
      logic [63:0] front;
      if (reset) begin
         chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
         chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
         sb.delete();
         exp_pc = RST_ADDR;
         disc   = 1'b0;
      end else begin
         emv = disc || (sb.size() < 4);
         chk("mem_valid", {31'b0, mem_valid}, {31'b0, emv});
         if (emv) chk("mem_address", mem_address, disc ? hold : exp_pc);
         eov = (sb.size() != 0);
`ifdef FETCH_QUEUE_BYPASS_EN
         if (!disc && sb.size() == 0 && mem_ready && !flush) eov = 1'b1;
`endif
         chk("out_valid", {31'b0, out_valid}, {31'b0, eov});
         if (!flush) begin
            if (!disc && emv && mem_ready) begin
               sb.push_back({exp_pc, memf(exp_pc)});
               exp_pc = exp_pc + 32'd4;
            end else if (disc && mem_ready) begin
               disc = 1'b0;
            end
            if (eov && out_ready) begin
               if (sb.size() == 0) begin
                  chk("sb_empty", 32'd1, 32'd0);
               end else begin
                  front = sb.pop_front();
                  chk("out_pc", out_pc, front[63:32]);
                  chk("out_instr", out_instr, front[31:0]);
                  npop++;
               end
            end
         end else begin
            if (!disc && emv && !mem_ready) begin
               disc = 1'b1;
               hold = exp_pc;
            end else if (disc && mem_ready) begin
               disc = 1'b0;
            end
            sb.delete();
            exp_pc = flush_pc & ~32'h3;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Memory with 0-3 wait states per request.
   task automatic drive_rand_mem();
      if (mem_ready) ws = $urandom_range(0, 3);
      else if (mem_valid && ws != 0) ws--;
      mem_ready = mem_valid && (ws == 0);
   endtask

   initial begin
      int p0;
      reset = 1'b1; flush = 1'b0; flush_pc = '0; mem_ready = 1'b0; out_ready = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_addr", mem_address, RST_ADDR);
      chk("post_rst_out_valid", {31'b0, out_valid}, 32'd0);

      // Fill to full with no consumer.
      step();
      mem_ready = 1'b1;
      repeat (6) step();
      @(negedge clk);
      chk("full_mem_valid", {31'b0, mem_valid}, 32'd0);
      chk("full_out_valid", {31'b0, out_valid}, 32'd1);
      chk("full_head_pc", out_pc, 32'h100);
      chk("full_head_instr", out_instr, memf(32'h100));

      // Empty the queue with a flush, then stream.
      step();
      mem_ready = 1'b0; flush = 1'b1; flush_pc = 32'h300;
      step();
      flush = 1'b0; mem_ready = 1'b1; out_ready = 1'b1;
      p0 = npop;
      repeat (20) step();
      chk("stream_pops", {31'b0, (npop - p0) >= 18}, 32'd1);

      // Flush while a request is stalled by the memory.
      reset = 1'b1; mem_ready = 1'b0; out_ready = 1'b0;
      repeat (2) step();
      reset = 1'b0; mem_ready = 1'b1;
      repeat (3) step();
      mem_ready = 1'b0;
      step();
      flush = 1'b1; flush_pc = 32'h203;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("discard_hold_addr", mem_address, 32'h10C);
      step();
      step();
      mem_ready = 1'b1;
      step();
      @(negedge clk);
      chk("after_discard_addr", mem_address, 32'h200);
      chk("after_discard_out_valid", {31'b0, out_valid}, 32'd0);
      step();
      step();

      // Flush coinciding with a response and a consume.
      out_ready = 1'b1; mem_ready = 1'b1; flush = 1'b1; flush_pc = 32'h400;
      step();
      flush = 1'b0; mem_ready = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      chk("flush_rdy_addr", mem_address, 32'h400);
      chk("flush_rdy_mem_valid", {31'b0, mem_valid}, 32'd1);
      chk("flush_rdy_out_valid", {31'b0, out_valid}, 32'd0);

      // Address wrap through 2^32.
      step();
      mem_ready = 1'b1; out_ready = 1'b1; flush = 1'b1; flush_pc = 32'hFFFF_FFF8;
      step();
      flush = 1'b0;
      @(negedge clk);
      chk("wrap_0", mem_address, 32'hFFFF_FFF8);
      step();
      @(negedge clk);
      chk("wrap_1", mem_address, 32'hFFFF_FFFC);
      step();
      @(negedge clk);
      chk("wrap_2", mem_address, 32'h0);
      step();

      // Random backpressure, wait states and occasional flushes.
      mem_ready = 1'b0;
      p0 = npop;
      for (int i = 0; i < 1000; i++) begin
         out_ready = ($urandom_range(0, 1) == 1);
         flush     = ($urandom_range(0, 49) == 0);
         flush_pc  = $urandom;
         drive_rand_mem();
         step();
      end
      flush = 1'b0; out_ready = 1'b1;
      repeat (10) begin
         drive_rand_mem();
         step();
      end
      chk("random_progress", {31'b0, (npop - p0) > 100}, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
      $finish;
   end

endmodule
